fpu_mul_32bit: RTL and testbench
================================

FPU_MUL_32BIT -- requirements
Module: fpu_mul_32bit

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  in  1  request; sampled only when Ready=1.
REQ-004 SHALL have ports: A, B  in  32 each  IEEE-754 single operands, captured on the start edge.
REQ-005 SHALL have ports: S  out  32  product; held stable from Done until the next accepted start.
REQ-006 SHALL have ports: Done  out  1  one-cycle pulse marking S and flags valid.
REQ-007 SHALL have ports: Ready  out  1  high only in IDLE.
REQ-008 SHALL have ports: Error, Inf, NaN, Zero  out  1 each  result flags, valid with Done and held with S.

Function
REQ-009 SHALL use states IDLE, UNPACK, MUL, NORM, ROUND, DONE, with DONE returning to IDLE after one cycle.
REQ-010 SHALL ignore start when Ready=0; a start held high re-triggers only once back in IDLE.
REQ-011 SHALL, in UNPACK, flush denormal inputs to zero and classify each operand as zero, Inf, NaN or normal.
REQ-012 SHALL, for special cases, go UNPACK->DONE with Done on the 3rd rising edge after the start-sampling edge:
- NaN operand, or 0xInf: S=0x7FC00000, NaN=1, Error=1.
- Inf x nonzero: S=sign|0x7F800000, Inf=1.
- zero x finite: S=sign|0, Zero=1.
REQ-013 SHALL, for normal operands, form the 48-bit mantissa product by iterative shift-add, one multiplier bit per cycle over 24 MUL cycles; Done on the 28th edge after start.
REQ-014 SHALL set sign = A[31]^B[31] and exponent = eA+eB-127 at 10-bit signed width.
REQ-015 SHALL, in NORM, shift right by one and increment the exponent when product bit 47 = 1.
REQ-016 SHALL, in ROUND, handle exponent over- and underflow:
- Rounding carry-out renormalises the result.
- Exponent >=255: S=sign|0x7F800000, Inf=1, Error=1.
- Exponent <=0: S=sign|0, Zero=1.
REQ-017 SHALL assert exactly one flag combination per result; all flags are 0 for a normal finite result.

Reset
REQ-018 SHALL drive the following while rst_n=0: state=IDLE, S=0, Done=0, Error=Inf=NaN=Zero=0, Ready=1.
REQ-019 SHALL, when reset is asserted mid-operation, abort the operation with no Done, and accept start on the first edge after release.

Configuration
REQ-020 SHALL select rounding with macro FPU_MUL_RNE_EN:
- Defined: round to nearest, ties to even, using guard/round/sticky bits.
- Undefined: truncate toward zero, with guard/sticky logic compiled out.
- Latency is identical in both builds.

Structure
REQ-021 SHALL import package fpu_pkg, which holds:
- EXP_BIAS=127, MANT_W=24, EXP_W=8.
- QNAN=0x7FC00000, INF_POS=0x7F800000.
- The state enum and the operand-class enum.
REQ-022 SHALL place the 24-cycle shift-add engine in sub-module fpu_mul_mant_seq, which has a load/busy/valid handshake.

Verification
REQ-023 SHALL cover: A=0x40400000 (3.0), B=0x40000000 (2.0) -> S=0x40C00000, flags 0, Done on edge 28, single pulse.
REQ-024 SHALL cover: A=0x3FC00000, B=0x3F400000 -> S=0x3F900000 (1.125); then A=0x00000000, B=0x40700000 -> S=0, Zero=1, Done on edge 3.
REQ-025 SHALL cover: A=0x7F800000, B=0x00000000 -> S=0x7FC00000, NaN=1, Error=1; and A=0x7F000000, B=0x40000000 -> S=0x7F800000, Inf=1, Error=1.
REQ-026 SHALL cover: A=0x3F800005, B=0x3FC00000 -> S=0x3FC00008 with FPU_MUL_RNE_EN, S=0x3FC00007 without.
REQ-027 SHALL cover: start pulsed again while busy -> ignored, and S is unchanged until the original Done.
REQ-028 SHALL cover: rst_n low at MUL cycle 10 -> no Done, outputs at reset values, and a new start completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants, state/operand-class types and the operand classifier
// for the single-precision sequential multiplier.
package fpu_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned EXP_W    = 8;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] INF_POS = 32'h7F80_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MUL,
    NORM,
    ROUND,
    DONE
  } fpu_state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_NORM
  } op_class_e;

  // Denormals (exponent field 0) are treated as zero.
  function automatic op_class_e classify(input logic [31:0] x);
    logic [EXP_W-1:0]  e;
    logic [MANT_W-2:0] m;
    e = x[30 -: EXP_W];
    m = x[MANT_W-2:0];
    if (e == '0) begin
      return CLS_ZERO;
    end else if (e == '1) begin
      return (m != '0) ? CLS_NAN : CLS_INF;
    end
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/fpu_mul_mant_seq.sv
// Iterative shift-add mantissa multiplier: one multiplier bit per cycle,
// MANT_W cycles after load; valid pulses once when the product is complete.
module fpu_mul_mant_seq
  import fpu_pkg::*;
#(
  parameter int unsigned PROD_W = 2 * MANT_W
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [MANT_W-1:0] a_i,
  input  logic [MANT_W-1:0] b_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [PROD_W-1:0] prod_o
);

  logic [2*MANT_W-1:0] acc_q, acc_d;
  logic [2*MANT_W-1:0] mcand_q, mcand_d;
  logic [MANT_W-1:0]   mplier_q, mplier_d;
  logic [4:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{MANT_W{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 5'd1;
      if (cnt_q == 5'(MANT_W - 1)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign prod_o  = acc_q[2*MANT_W-1 -: PROD_W];

endmodule

// File: rtl/fpu_mul_32bit.sv
// Sequential IEEE-754 single-precision multiplier with flush-to-zero.
// FPU_MUL_RNE_EN selects round-to-nearest-even; otherwise results truncate.
module fpu_mul_32bit
  import fpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        Done,
  output logic        Ready,
  output logic        Error,
  output logic        Inf,
  output logic        NaN,
  output logic        Zero
);

`ifdef FPU_MUL_RNE_EN
  localparam int unsigned PROD_W = 2 * MANT_W;
`else
  localparam int unsigned PROD_W = MANT_W + 1;
`endif

  fpu_state_e        state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [1:0]        ucnt_q, ucnt_d;
  logic signed [9:0] exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
`ifdef FPU_MUL_RNE_EN
  logic [2:0]        grs_q, grs_d;
`endif
  logic [31:0]       s_q, s_d;
  logic [3:0]        fl_q, fl_d;
  logic              done_q, done_d;

  logic              mul_load, mul_busy, mul_valid, lead;
  logic [PROD_W-1:0] prod;
  op_class_e         cls_a, cls_b;
  logic              sign, special;
  logic [31:0]       spec_s, rnd_s;
  logic [3:0]        spec_fl, rnd_fl;
  logic              round_up;
  logic [MANT_W:0]   mant_r;
  logic signed [9:0] exp_r;

  fpu_mul_mant_seq #(.PROD_W(PROD_W)) u_mant (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .load_i  (mul_load),
    .a_i     ({1'b1, a_q[MANT_W-2:0]}),
    .b_i     ({1'b1, b_q[MANT_W-2:0]}),
    .busy_o  (mul_busy),
    .valid_o (mul_valid),
    .prod_o  (prod)
  );

  assign lead = prod[PROD_W-1];

  // Flags are packed {Error, Inf, NaN, Zero}.
  always_comb begin
    cls_a   = classify(a_q);
    cls_b   = classify(b_q);
    sign    = a_q[31] ^ b_q[31];
    special = (cls_a != CLS_NORM) || (cls_b != CLS_NORM);
    spec_s  = {sign, 31'b0};
    spec_fl = 4'b0001;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
        (cls_a == CLS_INF && cls_b == CLS_ZERO) ||
        (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      spec_s  = QNAN;
      spec_fl = 4'b1010;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      spec_s  = {sign, INF_POS[30:0]};
      spec_fl = 4'b0100;
    end
  end

  always_comb begin
`ifdef FPU_MUL_RNE_EN
    round_up = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[0]);
`else
    round_up = 1'b0;
`endif
    mant_r = {1'b0, mant_q} + {{MANT_W{1'b0}}, round_up};
    exp_r  = exp_q + (mant_r[MANT_W] ? 10'sd1 : 10'sd0);
    rnd_s  = {sign, exp_r[7:0],
              mant_r[MANT_W] ? mant_r[MANT_W-1:1] : mant_r[MANT_W-2:0]};
    rnd_fl = '0;
    if (exp_r >= 10'sd255) begin
      rnd_s  = {sign, INF_POS[30:0]};
      rnd_fl = 4'b1100;
    end else if (exp_r <= 10'sd0) begin
      rnd_s  = {sign, 31'b0};
      rnd_fl = 4'b0001;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ucnt_d   = ucnt_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
`ifdef FPU_MUL_RNE_EN
    grs_d    = grs_q;
`endif
    s_d      = s_q;
    fl_d     = fl_q;
    done_d   = 1'b0;
    mul_load = 1'b0;
    case (state_q)
      IDLE: begin
        ucnt_d = '0;
        if (start) begin
          a_d     = A;
          b_d     = B;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        // Special operands dwell here so their result lands on a fixed 3-edge latency.
        if (special) begin
          ucnt_d = ucnt_q + 2'd1;
          if (ucnt_q == 2'd2) begin
            s_d     = spec_s;
            fl_d    = spec_fl;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (!mul_busy) begin
          mul_load = 1'b1;
          exp_d    = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]})
                     - $signed(10'(EXP_BIAS));
          state_d  = MUL;
        end
      end
      MUL: begin
        if (mul_valid) begin
          state_d = NORM;
        end
      end
      NORM: begin
        // Selecting the upper window when bit 47 is set is the right-shift-by-one.
        mant_d = lead ? prod[PROD_W-1 -: MANT_W] : prod[PROD_W-2 -: MANT_W];
        exp_d  = exp_q + (lead ? 10'sd1 : 10'sd0);
`ifdef FPU_MUL_RNE_EN
        grs_d  = lead ? {prod[23], prod[22], |prod[21:0]}
                      : {prod[22], prod[21], |prod[20:0]};
`endif
        state_d = ROUND;
      end
      ROUND: begin
        s_d     = rnd_s;
        fl_d    = rnd_fl;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ucnt_q  <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
`ifdef FPU_MUL_RNE_EN
      grs_q   <= '0;
`endif
      s_q     <= '0;
      fl_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ucnt_q  <= ucnt_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
`ifdef FPU_MUL_RNE_EN
      grs_q   <= grs_d;
`endif
      s_q     <= s_d;
      fl_q    <= fl_d;
      done_q  <= done_d;
    end
  end

  assign S     = s_q;
  assign Done  = done_q;
  assign Ready = (state_q == IDLE);
  assign Error = fl_q[3];
  assign Inf   = fl_q[2];
  assign NaN   = fl_q[1];
  assign Zero  = fl_q[0];

endmodule

// File: tb/tb_fpu_mul_32bit.sv
// Directed-vector bench for fpu_mul_32bit: result/flag/latency table plus
// busy-restart and mid-operation reset sequences.
module tb_fpu_mul_32bit;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] A, B, S;
  logic        Done, Ready, Error, Inf, NaN, Zero;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fpu_mul_32bit dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .S     (S),
    .Done  (Done),
    .Ready (Ready),
    .Error (Error),
    .Inf   (Inf),
    .NaN   (NaN),
    .Zero  (Zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [3:0]  fl;   // {Error, Inf, NaN, Zero}
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'b0, Error, Inf, NaN, Zero};
  endfunction

  // Called #1 after a rising edge; the next edge samples start.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk_i);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk_i);
      #1;
      if (Done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] prev_s;
    logic        hold_ok;

    vecs.push_back('{32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 4'b0000, 28});
    vecs.push_back('{32'h3FC0_0000, 32'h3F40_0000, 32'h3F90_0000, 4'b0000, 28});
    vecs.push_back('{32'h0000_0000, 32'h4070_0000, 32'h0000_0000, 4'b0001, 3});
    vecs.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1010, 3});
    vecs.push_back('{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b1100, 28});
`ifdef FPU_MUL_RNE_EN
    vecs.push_back('{32'h3F80_0005, 32'h3FC0_0000, 32'h3FC0_0008, 4'b0000, 28});
    vecs.push_back('{32'h3F80_0001, 32'h3FFF_FFFE, 32'h4000_0000, 4'b0000, 28});
`else
    vecs.push_back('{32'h3F80_0005, 32'h3FC0_0000, 32'h3FC0_0007, 4'b0000, 28});
    vecs.push_back('{32'h3F80_0001, 32'h3FFF_FFFE, 32'h3FFF_FFFF, 4'b0000, 28});
`endif
    vecs.push_back('{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1010, 3});
    vecs.push_back('{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0100, 3});
    vecs.push_back('{32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 4'b0001, 3});
    vecs.push_back('{32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000, 28});
    vecs.push_back('{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0001, 28});
    vecs.push_back('{32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 4'b0001, 3});

    rst_n = 1'b0;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_S", S, 32'h0);
    check("rst_done", {31'b0, Done}, 32'h0);
    check("rst_flags", flags(), 32'h0);
    check("rst_ready", {31'b0, Ready}, 32'h1);
    rst_n = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_S", i), S, vecs[i].s);
      check($sformatf("v%0d_flags", i), flags(), {28'b0, vecs[i].fl});
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_pulse", i), {31'b0, Done}, 32'h0);
      check($sformatf("v%0d_hold", i), S, vecs[i].s);
    end

    // Start held high through an operation with operands changing under it.
    prev_s  = S;
    hold_ok = 1'b1;
    A = 32'h4040_0000;
    B = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk_i);
    #1;
    A = 32'h3FC0_0000;
    B = 32'h3F40_0000;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk_i);
      #1;
      if (Done) begin
        lat = n;
        break;
      end
      if (S !== prev_s || Ready !== 1'b0) hold_ok = 1'b0;
    end
    check("busy_lat", 32'(lat), 32'd28);
    check("busy_S", S, 32'h40C0_0000);
    check("busy_hold", {31'b0, hold_ok}, 32'h1);
    @(posedge clk_i);
    #1;
    check("retrig_ready", {31'b0, Ready}, 32'h1);
    @(posedge clk_i);
    #1;
    start = 1'b0;
    check("retrig_taken", {31'b0, Ready}, 32'h0);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk_i);
      #1;
      if (Done) begin
        lat = n;
        break;
      end
    end
    check("retrig_lat", 32'(lat), 32'd28);
    check("retrig_S", S, 32'h3F90_0000);
    @(posedge clk_i);
    #1;

    // Reset asserted during MUL aborts the operation.
    A = 32'h4040_0000;
    B = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk_i);
    #1 start = 1'b0;
    repeat (11) @(posedge clk_i);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_S", S, 32'h0);
    check("mid_rst_done", {31'b0, Done}, 32'h0);
    check("mid_rst_flags", flags(), 32'h0);
    check("mid_rst_ready", {31'b0, Ready}, 32'h1);
    repeat (2) @(posedge clk_i);
    #1 rst_n = 1'b1;
    run_op(32'h3FC0_0000, 32'h3F40_0000, lat);
    check("post_rst_lat", 32'(lat), 32'd28);
    check("post_rst_S", S, 32'h3F90_0000);
    check("post_rst_flags", flags(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
